// File: rtl/pkt_rx_pkg.sv
// Shared definitions for the packet-RX framer: state encoding, header layout and patterns.
package pkt_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PAY  = 3'd2,
    ST_TRL  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [31:0] DEF_SYNC_WORD = 32'hEB90_146F;
  localparam logic [31:0] TRAILER_PAT   = 32'hA5A5_A5A5;

  localparam int unsigned HDR_SYNC_LSB = 96;
  localparam int unsigned HDR_SEQ_LSB  = 64;
  localparam int unsigned HDR_CHAN_LSB = 48;
  localparam int unsigned HDR_LEN_LSB  = 32;

  function automatic logic [127:0] build_header(input logic [31:0] sync,
                                                input logic [31:0] seq,
                                                input logic [15:0] chan,
                                                input logic [15:0] len);
    logic [127:0] h;
    h = '0;
    h[HDR_SYNC_LSB +: 32] = sync;
    h[HDR_SEQ_LSB  +: 32] = seq;
    h[HDR_CHAN_LSB +: 16] = chan;
    h[HDR_LEN_LSB  +: 16] = len;
    return h;
  endfunction

endpackage

// File: rtl/pkt_lane_packer.sv
// Packs accepted 32-bit samples MSB-first into 128-bit words; word_done marks the
// cycle the fourth sample arrives, with the complete word presented on word.
module pkt_lane_packer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_vld,
  input  logic [31:0]  in_data,
  output logic [127:0] word,
  output logic         word_done
);

  logic [95:0] shreg_q, shreg_d;
  logic [1:0]  lane_q, lane_d;

  always_comb begin
    shreg_d = shreg_q;
    lane_d  = lane_q;
    if (clr) begin
      shreg_d = '0;
      lane_d  = '0;
    end else if (in_vld) begin
      shreg_d = {shreg_q[63:0], in_data};
      lane_d  = lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      lane_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      lane_q  <= lane_d;
    end
  end

  // Earlier samples already sit in the upper lanes; the arriving one fills [31:0].
  assign word      = {shreg_q, in_data};
  assign word_done = in_vld && !clr && (lane_q == 2'd3);

endmodule

// File: rtl/pkt_rx_framer.sv
// Frames a 32-bit sample stream into fixed-length 128-bit-word packets for the RX FIFO.
// Define PKT_RX_FRAMER_CHECKSUM_EN to append a checksum trailer as the last frame word.
module pkt_rx_framer
  import pkt_rx_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 4,
  parameter logic [31:0] SYNC_WORD   = DEF_SYNC_WORD,
  parameter logic [15:0] CHAN_ID     = 16'h0001
) (
  input  logic         PL_CLK,
  input  logic         RESETn,
  input  logic         enable,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic         fifo_wrreq_pkt_rx,
  output logic [127:0] fifo_data_pkt_rx,
  input  logic         fifo_prog_full_pkt_rx,
  output logic         busy,
  output logic [31:0]  frame_cnt
);

`ifdef PKT_RX_FRAMER_CHECKSUM_EN
  localparam int unsigned PAY_WORDS = FRAME_WORDS - 2;
`else
  localparam int unsigned PAY_WORDS = FRAME_WORDS - 1;
`endif
  localparam logic [15:0] FRAME_LEN = 16'(FRAME_WORDS);
  localparam logic [15:0] LAST_PAY  = 16'(PAY_WORDS - 1);

  state_e        state_q, state_d;
  logic          s_ready_q, s_ready_d;
  logic          wrreq_q, wrreq_d;
  logic [127:0]  data_q, data_d;
  logic          busy_q, busy_d;
  logic [31:0]   frame_cnt_q, frame_cnt_d;
  logic [31:0]   seq_q, seq_d;
  logic [15:0]   pay_cnt_q, pay_cnt_d;
`ifdef PKT_RX_FRAMER_CHECKSUM_EN
  logic [31:0]   sum_q, sum_d;
`endif

  logic          accept;
  logic          packer_clr;
  logic          word_done;
  logic [127:0]  packed_word;

  assign accept     = (state_q == ST_PAY) && s_valid && s_ready_q;
  assign packer_clr = (state_q == ST_HDR);

  pkt_lane_packer u_packer (
    .clk       (PL_CLK),
    .rst_n     (RESETn),
    .clr       (packer_clr),
    .in_vld    (accept),
    .in_data   (s_data),
    .word      (packed_word),
    .word_done (word_done)
  );

  always_comb begin
    state_d     = state_q;
    wrreq_d     = 1'b0;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;
    seq_d       = seq_q;
    pay_cnt_d   = pay_cnt_q;
`ifdef PKT_RX_FRAMER_CHECKSUM_EN
    sum_d       = accept ? (sum_q + s_data) : sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_prog_full_pkt_rx) state_d = ST_HDR;
      end
      ST_HDR: begin
        wrreq_d   = 1'b1;
        data_d    = build_header(SYNC_WORD, seq_q, CHAN_ID, FRAME_LEN);
        pay_cnt_d = '0;
`ifdef PKT_RX_FRAMER_CHECKSUM_EN
        sum_d     = '0;
`endif
        state_d   = ST_PAY;
      end
      ST_PAY: begin
        // A completed word is always written; prog_full headroom covers it.
        if (word_done) begin
          wrreq_d   = 1'b1;
          data_d    = packed_word;
          pay_cnt_d = pay_cnt_q + 16'd1;
          if (pay_cnt_q == LAST_PAY) begin
`ifdef PKT_RX_FRAMER_CHECKSUM_EN
            state_d = ST_TRL;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef PKT_RX_FRAMER_CHECKSUM_EN
      ST_TRL: begin
        wrreq_d = 1'b1;
        data_d  = {sum_q, ~sum_q, TRAILER_PAT, seq_q};
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        frame_cnt_d = frame_cnt_q + 32'd1;
        seq_d       = seq_q + 32'd1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Leaving PAY after the last sample drops s_ready, so nothing of the next frame is taken early.
    s_ready_d = (state_d == ST_PAY) && !fifo_prog_full_pkt_rx;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge PL_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= ST_IDLE;
      s_ready_q   <= 1'b0;
      wrreq_q     <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      seq_q       <= '0;
      pay_cnt_q   <= '0;
`ifdef PKT_RX_FRAMER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      wrreq_q     <= wrreq_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      seq_q       <= seq_d;
      pay_cnt_q   <= pay_cnt_d;
`ifdef PKT_RX_FRAMER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign s_ready           = s_ready_q;
  assign fifo_wrreq_pkt_rx = wrreq_q;
  assign fifo_data_pkt_rx  = data_q;
  assign busy              = busy_q;
  assign frame_cnt         = frame_cnt_q;

endmodule

// File: tb/tb_pkt_rx_framer.sv
// Directed bench for pkt_rx_framer (FRAME_WORDS=4); follows PKT_RX_FRAMER_CHECKSUM_EN.
module tb_pkt_rx_framer;

  localparam int FW = 4;
`ifdef PKT_RX_FRAMER_CHECKSUM_EN
  localparam int P = FW - 2;
`else
  localparam int P = FW - 1;
`endif

  logic         PL_CLK = 1'b0;
  logic         RESETn;
  logic         enable;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic         fifo_wrreq_pkt_rx;
  logic [127:0] fifo_data_pkt_rx;
  logic         fifo_prog_full_pkt_rx;
  logic         busy;
  logic [31:0]  frame_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] wq[$];

  pkt_rx_framer #(.FRAME_WORDS(FW)) dut (
    .PL_CLK                (PL_CLK),
    .RESETn                (RESETn),
    .enable                (enable),
    .s_data                (s_data),
    .s_valid               (s_valid),
    .s_ready               (s_ready),
    .fifo_wrreq_pkt_rx     (fifo_wrreq_pkt_rx),
    .fifo_data_pkt_rx      (fifo_data_pkt_rx),
    .fifo_prog_full_pkt_rx (fifo_prog_full_pkt_rx),
    .busy                  (busy),
    .frame_cnt             (frame_cnt)
  );

  always #5 PL_CLK = ~PL_CLK;

  always @(negedge PL_CLK) begin
    if (fifo_wrreq_pkt_rx) wq.push_back(fifo_data_pkt_rx);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one sample from a negedge and returns at the negedge after it is taken.
  task automatic push(input logic [31:0] d);
    int t = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && t < 300) begin
      @(negedge PL_CLK);
      t++;
    end
    if (t >= 300) chk_vec($sformatf("s_ready_timeout_%0d", d), {127'b0, s_ready}, 128'd1);
    @(negedge PL_CLK);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 100) begin
      @(negedge PL_CLK);
      t++;
    end
    chk_vec({tag, "_busy_fall"}, {127'b0, busy}, 128'd0);
  endtask

  task automatic bp_window(input logic [31:0] next_d);
    int n0;
    int viol = 0;
    s_valid = 1'b0;
    fifo_prog_full_pkt_rx = 1'b1;
    @(negedge PL_CLK);
    n0 = wq.size();
    s_data  = next_d;
    s_valid = 1'b1;
    repeat (9) begin
      @(negedge PL_CLK);
      if (s_ready) viol++;
    end
    chk_vec("bp_s_ready_high_cycles", 128'(viol), 128'd0);
    chk_vec("bp_writes_during_full", 128'(wq.size() - n0), 128'd0);
    fifo_prog_full_pkt_rx = 1'b0;
  endtask

  // One frame: enable is dropped after the second sample, so exactly one frame is produced.
  task automatic run_frame(input string tag, input logic [31:0] seq, input logic [31:0] base,
                           input bit with_bp);
    logic [127:0] expq[$];
    logic [31:0]  sum = '0;
    wq.delete();
    expq.push_back({32'hEB90_146F, seq, 16'h0001, 16'(FW), 32'h0});
    for (int w = 0; w < P; w++) begin
      expq.push_back({base + 32'(4*w), base + 32'(4*w+1), base + 32'(4*w+2), base + 32'(4*w+3)});
      for (int k = 0; k < 4; k++) sum = sum + base + 32'(4*w+k);
    end
`ifdef PKT_RX_FRAMER_CHECKSUM_EN
    expq.push_back({sum, ~sum, 32'hA5A5_A5A5, seq});
`endif
    enable = 1'b1;
    for (int i = 0; i < 4*P; i++) begin
      push(base + 32'(i));
      if (i == 1) enable = 1'b0;
      if (with_bp && i == 5) bp_window(base + 32'(i + 1));
    end
    s_valid = 1'b0;
    chk_vec({tag, "_s_ready_after_last"}, {127'b0, s_ready}, 128'd0);
    wait_idle(tag);
    repeat (4) @(negedge PL_CLK);
    chk_vec({tag, "_word_count"}, 128'(wq.size()), 128'(FW));
    for (int k = 0; k < FW; k++)
      if (k < wq.size()) chk_vec($sformatf("%s_w%0d", tag, k), wq[k], expq[k]);
  endtask

  initial begin
    RESETn = 1'b0;
    enable = 1'b0;
    s_data = '0;
    s_valid = 1'b0;
    fifo_prog_full_pkt_rx = 1'b0;
    repeat (3) @(negedge PL_CLK);
    chk_vec("rst_s_ready", {127'b0, s_ready}, 128'd0);
    chk_vec("rst_wrreq", {127'b0, fifo_wrreq_pkt_rx}, 128'd0);
    chk_vec("rst_data", fifo_data_pkt_rx, 128'd0);
    chk_vec("rst_busy", {127'b0, busy}, 128'd0);
    chk_vec("rst_frame_cnt", 128'(frame_cnt), 128'd0);
    RESETn = 1'b1;
    @(negedge PL_CLK);

    // Frame 0: samples 1.., enable dropped after sample 2.
    run_frame("f0", 32'd0, 32'd1, 1'b0);
    if (wq.size() >= FW) begin
      chk_vec("f0_hdr_literal", wq[0], 128'hEB90146F_00000000_00010004_00000000);
      chk_vec("f0_pay0_literal", wq[1], 128'h00000001_00000002_00000003_00000004);
`ifdef PKT_RX_FRAMER_CHECKSUM_EN
      chk_vec("f0_pay1_literal", wq[2], 128'h00000005_00000006_00000007_00000008);
      chk_vec("f0_trl_literal", wq[3], 128'h00000024_FFFFFFDB_A5A5A5A5_00000000);
`else
      chk_vec("f0_pay2_literal", wq[3], 128'h00000009_0000000A_0000000B_0000000C);
`endif
    end
    chk_vec("f0_frame_cnt", 128'(frame_cnt), 128'd1);

    // prog_full blocks a new frame start.
    wq.delete();
    fifo_prog_full_pkt_rx = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge PL_CLK);
    chk_vec("pf_gate_busy", {127'b0, busy}, 128'd0);
    chk_vec("pf_gate_writes", 128'(wq.size()), 128'd0);
    enable = 1'b0;
    fifo_prog_full_pkt_rx = 1'b0;
    @(negedge PL_CLK);

    // Frame 1 with a back-pressure window after sample 6.
    run_frame("f1_bp", 32'd1, 32'h100, 1'b1);
    chk_vec("f1_frame_cnt", 128'(frame_cnt), 128'd2);

    // Reset in the middle of the payload.
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(32'h200 + 32'(i));
      if (i == 1) enable = 1'b0;
    end
    s_valid = 1'b0;
    RESETn  = 1'b0;
    @(negedge PL_CLK);
    chk_vec("midrst_s_ready", {127'b0, s_ready}, 128'd0);
    chk_vec("midrst_wrreq", {127'b0, fifo_wrreq_pkt_rx}, 128'd0);
    chk_vec("midrst_data", fifo_data_pkt_rx, 128'd0);
    chk_vec("midrst_busy", {127'b0, busy}, 128'd0);
    chk_vec("midrst_frame_cnt", 128'(frame_cnt), 128'd0);
    RESETn = 1'b1;
    @(negedge PL_CLK);
    run_frame("f_postrst", 32'd0, 32'h300, 1'b0);
    chk_vec("postrst_frame_cnt", 128'(frame_cnt), 128'd1);

    // Sequence wrap.
    force dut.seq_q = 32'hFFFF_FFFF;
    @(negedge PL_CLK);
    release dut.seq_q;
    @(negedge PL_CLK);
    run_frame("f_wrap_hi", 32'hFFFF_FFFF, 32'h400, 1'b0);
    run_frame("f_wrap_lo", 32'd0, 32'h500, 1'b0);
    chk_vec("wrap_frame_cnt", 128'(frame_cnt), 128'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
